// File: rtl/best_sad_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module      : best_sad_tracker_if
//  Description : Bundles the per-cycle SAD input and the search-result outputs
//                of best_sad_tracker.
//                master : producer of the per-cycle winners, and consumer of the results
//                slave  : the tracker itself
//  Ports       : start, sad_valid, best_sad_cicle, address_best_sad_cicle (to tracker)
//                busy, done, best_sad, best_index, addr_err            (from tracker)
//  Revision    : 1.0 - initial release
// ============================================================================
interface best_sad_tracker_if #(
    parameter int SAD_WIDTH = 16,
    parameter int IDX_WIDTH = 6
);
    logic                 start;
    logic                 sad_valid;
    logic [SAD_WIDTH-1:0] best_sad_cicle;
    logic [2:0]           address_best_sad_cicle;
    logic                 busy;
    logic                 done;
    logic [SAD_WIDTH-1:0] best_sad;
    logic [IDX_WIDTH-1:0] best_index;
    logic                 addr_err;

    modport master (
        output start, sad_valid, best_sad_cicle, address_best_sad_cicle,
        input  busy, done, best_sad, best_index, addr_err
    );

    modport slave (
        input  start, sad_valid, best_sad_cicle, address_best_sad_cicle,
        output busy, done, best_sad, best_index, addr_err
    );
endinterface
`default_nettype wire

// File: rtl/best_sad_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : best_sad_tracker
//  Description : Keeps the running minimum of the per-cycle winning SADs over
//                NUM_CICLES valid cycles of one block search. It reports the global
//                best SAD and its candidate index (cicle*CAND_PER_CICLE + address).
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - best_sad_tracker_if.slave (start/sad_valid/SAD/address in;
//                         busy/done/best_sad/best_index/addr_err out, all registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module best_sad_tracker #(
    parameter int SAD_WIDTH      = 16,
    parameter int CAND_PER_CICLE = 6,
    parameter int NUM_CICLES     = 8,
    parameter int IDX_WIDTH      = 6
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    best_sad_tracker_if.slave  bus
);

    localparam int c_CNT_WIDTH = $clog2(NUM_CICLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [c_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [SAD_WIDTH-1:0]   best_sad_q, best_sad_d;
    logic [IDX_WIDTH-1:0]   best_idx_q, best_idx_d;
    logic                   addr_err_q, addr_err_d;

    logic                   addr_legal;
    logic                   first_valid;
    logic                   last_valid;
    logic [IDX_WIDTH-1:0]   cand_idx;

    assign addr_legal  = 32'(bus.address_best_sad_cicle) < 32'(CAND_PER_CICLE);
    assign first_valid = (cnt_q == '0);
    assign last_valid  = (cnt_q == c_CNT_WIDTH'(NUM_CICLES - 1));
    // Index fits IDX_WIDTH by parameter choice, so truncation of the 32-bit
    // product only drops bits that are always zero.
    assign cand_idx    = IDX_WIDTH'(32'(cnt_q) * 32'(CAND_PER_CICLE)
                                    + 32'(bus.address_best_sad_cicle));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            best_sad_q <= '1;
            best_idx_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            best_sad_q <= best_sad_d;
            best_idx_q <= best_idx_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        best_sad_d = best_sad_q;
        best_idx_d = best_idx_q;
        addr_err_d = addr_err_q;

        // start wins over everything, including a sad_valid in the same cycle.
        if (bus.start) begin
            state_d    = S_ACCUM;
            cnt_d      = '0;
            best_sad_d = '1;
            best_idx_d = '0;
            addr_err_d = 1'b0;
        end else begin
            case (state_q)
                S_ACCUM: begin
                    if (bus.sad_valid) begin
                        cnt_d = cnt_q + 1'b1;
                        if (addr_legal) begin
                            // First cycle always loads so an all-ones SAD still
                            // yields an index from cycle 0; afterwards strict
                            // less-than keeps the earliest of equal SADs.
                            if (first_valid || (bus.best_sad_cicle < best_sad_q)) begin
                                best_sad_d = bus.best_sad_cicle;
                                best_idx_d = cand_idx;
                            end
                        end else begin
                            addr_err_d = 1'b1;
                        end
                        if (last_valid) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.busy       = (state_q == S_ACCUM);
    assign bus.done       = (state_q == S_DONE);
    assign bus.best_sad   = best_sad_q;
    assign bus.best_index = best_idx_q;
    assign bus.addr_err   = addr_err_q;

endmodule
`default_nettype wire
